// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution feeder: kernel ctrl encodings,
// sequencer states and the byte lanes of a three-row sample word.
package conv_pkg;

  localparam logic [3:0] CTRL_HOLD   = 4'b0100;
  localparam logic [3:0] CTRL_STOREW = 4'b0001;
  localparam logic [3:0] CTRL_LSB    = 4'b0010;
  localparam logic [3:0] CTRL_CIRC   = 4'b0100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WLOAD  = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam int unsigned LANE1_OFS = 0;
  localparam int unsigned LANE2_OFS = 8;
  localparam int unsigned LANE3_OFS = 16;

  function automatic logic [7:0] lane_sample(input logic [23:0] x, input int unsigned ofs);
    return x[ofs +: 8];
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Shift register carrying the {live, phase} tag of every output cycle so the
// result bus and the carry-select bit line up with the kernel's latency.
module tag_delay #(
  parameter int unsigned DEPTH = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tag_i,
  output logic [1:0] tap_o,
  output logic       pre_phase_o
);

  logic [1:0] stage_q [DEPTH];
  logic [1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= 2'b00;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tap_o       = stage_q[DEPTH-1];
  // Feeds a registered output, so take the stage one ahead of LAT-1.
  assign pre_phase_o = stage_q[DEPTH-3][0];

endmodule

// File: rtl/conv3x3_feeder.sv
// Sequencer for the 3x3 systolic kernel: weight load, LSB/circulate sample
// slots, flush, and tagging of the kernel's byte-serial result bus.
module conv3x3_feeder
  import conv_pkg::*;
#(
  parameter int unsigned N_X = 6,
  parameter int unsigned LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [3:0]  w_data,
  input  logic        x_valid,
  output logic        x_ready,
  input  logic [23:0] x_data,
  output logic [7:0]  k_in1,
  output logic [7:0]  k_in2,
  output logic [7:0]  k_in3,
  output logic [7:0]  k_yaux,
  output logic [3:0]  k_ctrl,
  output logic        busy,
  output logic        done,
  output logic        res_valid,
  output logic        res_hi,
  output logic        underrun
);

  state_t     state_q, state_d;
  logic       phase_q, phase_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [7:0] scnt_q, scnt_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [7:0] k_in1_q, k_in1_d, k_in2_q, k_in2_d, k_in3_q, k_in3_d;
  logic [3:0] k_ctrl_q, k_ctrl_d, ctrl_d;
  logic       w_ready_q, w_ready_d, x_ready_q, x_ready_d;
  logic       busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;
  logic [1:0] tag_d, tag_tap;
  logic       pre_phase;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    fcnt_d     = fcnt_q;
    k_in1_d    = k_in1_q;
    k_in2_d    = k_in2_q;
    k_in3_d    = k_in3_q;
    ctrl_d     = CTRL_HOLD;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    tag_d      = 2'b00;
    case (state_q)
      IDLE: begin
        k_in1_d = 8'h00;
        k_in2_d = 8'h00;
        k_in3_d = 8'h00;
        if (start) begin
          state_d    = WLOAD;
          phase_d    = 1'b0;
          wcnt_d     = 2'd0;
          underrun_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WLOAD: begin
        if (!phase_q) begin
          if (w_valid) begin
            ctrl_d  = CTRL_STOREW;
            k_in1_d = {4'b0000, w_data};
            k_in2_d = {4'b0000, w_data};
            k_in3_d = {4'b0000, w_data};
            phase_d = 1'b1;
          end else begin
            // Chain frozen while the weight source stalls; slot start retried.
            ctrl_d  = CTRL_HOLD;
            k_in1_d = 8'h00;
            k_in2_d = 8'h00;
            k_in3_d = 8'h00;
          end
        end else begin
          ctrl_d  = CTRL_STOREW;
          phase_d = 1'b0;
          if (wcnt_q == 2'd2) begin
            state_d = STREAM;
            scnt_d  = 8'd0;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end
      end
      STREAM: begin
        if (!phase_q) begin
          ctrl_d  = CTRL_LSB;
          tag_d   = 2'b10;
          phase_d = 1'b1;
          if (x_valid) begin
            k_in1_d = lane_sample(x_data, LANE1_OFS);
            k_in2_d = lane_sample(x_data, LANE2_OFS);
            k_in3_d = lane_sample(x_data, LANE3_OFS);
          end else begin
            k_in1_d    = 8'h00;
            k_in2_d    = 8'h00;
            k_in3_d    = 8'h00;
            underrun_d = 1'b1;
          end
        end else begin
          ctrl_d  = CTRL_CIRC;
          tag_d   = 2'b11;
          phase_d = 1'b0;
          if (scnt_q == 8'(N_X - 1)) begin
            state_d = FLUSH;
            fcnt_d  = 8'd0;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
      end
      FLUSH: begin
        k_in1_d = 8'h00;
        k_in2_d = 8'h00;
        k_in3_d = 8'h00;
        ctrl_d  = phase_q ? CTRL_CIRC : CTRL_LSB;
        phase_d = ~phase_q;
        if (fcnt_q == 8'(LAT - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
          phase_d = 1'b0;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    k_ctrl_d  = {pre_phase, ctrl_d[2:0]};
    w_ready_d = (state_d == WLOAD) && !phase_d;
    x_ready_d = (state_d == STREAM) && !phase_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      wcnt_q     <= 2'd0;
      scnt_q     <= 8'd0;
      fcnt_q     <= 8'd0;
      k_in1_q    <= 8'h00;
      k_in2_q    <= 8'h00;
      k_in3_q    <= 8'h00;
      k_ctrl_q   <= CTRL_HOLD;
      w_ready_q  <= 1'b0;
      x_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      wcnt_q     <= wcnt_d;
      scnt_q     <= scnt_d;
      fcnt_q     <= fcnt_d;
      k_in1_q    <= k_in1_d;
      k_in2_q    <= k_in2_d;
      k_in3_q    <= k_in3_d;
      k_ctrl_q   <= k_ctrl_d;
      w_ready_q  <= w_ready_d;
      x_ready_q  <= x_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  tag_delay #(.DEPTH(LAT + 1)) u_tag_delay (
    .clk         (clk),
    .rst         (rst),
    .tag_i       (tag_d),
    .tap_o       (tag_tap),
    .pre_phase_o (pre_phase)
  );

  assign k_in1     = k_in1_q;
  assign k_in2     = k_in2_q;
  assign k_in3     = k_in3_q;
  assign k_yaux    = 8'h00;
  assign k_ctrl    = k_ctrl_q;
  assign w_ready   = w_ready_q;
  assign x_ready   = x_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign res_valid = tag_tap[1];
  assign res_hi    = tag_tap[0];

endmodule

// File: tb/tb_conv3x3_feeder.sv
// Directed bench for conv3x3_feeder: weight load with and without stalls,
// sample streaming, underrun, start-while-busy and mid-frame reset.
module tb_conv3x3_feeder;

  localparam int N_X = 6;
  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst, start, w_valid, x_valid;
  logic [3:0]  w_data;
  logic [23:0] x_data;
  logic        w_ready, x_ready, busy, done, res_valid, res_hi, underrun;
  logic [7:0]  k_in1, k_in2, k_in3, k_yaux;
  logic [3:0]  k_ctrl;

  always #5 clk = ~clk;

  conv3x3_feeder #(.N_X(N_X), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .k_in1(k_in1), .k_in2(k_in2), .k_in3(k_in3), .k_yaux(k_yaux),
    .k_ctrl(k_ctrl), .busy(busy), .done(done),
    .res_valid(res_valid), .res_hi(res_hi), .underrun(underrun)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [3:0] wts [3] = '{4'hB, 4'h2, 4'h1};
  logic [7:0] smp [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F};

  // Per-cycle record of one frame, index = cycles after the edge that took start
  logic [3:0] r_ctrl [64];
  logic [7:0] r_in1 [64], r_in2 [64], r_in3 [64];
  logic       r_rv [64], r_rh [64], r_und [64], r_busy [64], r_xr [64];

  function automatic logic [7:0] row2(input logic [7:0] s); return ~s; endfunction
  function automatic logic [7:0] row3(input logic [7:0] s); return s + 8'h40; endfunction

  task automatic run_frame(input int wstall, input int drop, input int extra_start);
    int done_cyc = -1;
    int widx = 0, xidx = 0, stall_cnt = 0;
    int n_storew = 0, n_rv = 0, n_xr = 0;
    int base;
    for (int c = 0; c < 64; c++) begin
      r_ctrl[c] = 4'h0; r_in1[c] = 8'h00; r_in2[c] = 8'h00; r_in3[c] = 8'h00;
      r_rv[c] = 1'b0; r_rh[c] = 1'b0; r_und[c] = 1'b0; r_busy[c] = 1'b0; r_xr[c] = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c < 64; c++) begin
      @(posedge clk); #1;
      r_ctrl[c] = k_ctrl; r_in1[c] = k_in1; r_in2[c] = k_in2; r_in3[c] = k_in3;
      r_rv[c] = res_valid; r_rh[c] = res_hi; r_und[c] = underrun;
      r_busy[c] = busy; r_xr[c] = x_ready;
      start = (c == extra_start);
      w_data  = (widx < 3) ? wts[widx] : 4'h0;
      w_valid = (widx < 3) && !(widx == 1 && stall_cnt < wstall);
      if (w_ready && widx == 1 && stall_cnt < wstall) stall_cnt++;
      if (w_ready && w_valid) widx++;
      x_valid = 1'b0;
      x_data  = 24'h0;
      if (x_ready && xidx < N_X) begin
        if (xidx != drop) begin
          x_valid = 1'b1;
          x_data  = {row3(smp[xidx]), row2(smp[xidx]), smp[xidx]};
        end
        xidx++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;

    check_eq("done_cycle", done_cyc, 27 + wstall);
    check_eq("busy_first", r_busy[1], 1'b1);
    check_eq("busy_last", r_busy[26 + wstall], 1'b1);
    check_eq("underrun_clr", r_und[1], 1'b0);
    // Weight slots: 0B,0B, stall holds, 02,02,01,01
    for (int i = 0; i < 6 + wstall; i++) begin
      if (i >= 2 && i < 2 + wstall) begin
        check_eq("wload_hold", r_ctrl[2 + i], 4'b0100);
      end else begin
        check_eq("wload_ctrl", r_ctrl[2 + i], 4'b0001);
        check_eq("wload_in1", r_in1[2 + i], {4'h0, wts[(i < 2) ? 0 : (i - 2 - wstall) / 2 + 1]});
      end
    end
    base = 8 + wstall;
    for (int j = 0; j < 2 * N_X; j++) begin
      logic [7:0] s;
      s = (j / 2 == drop) ? 8'h00 : smp[j / 2];
      check_eq("stream_ctrl", r_ctrl[base + j][2:0], (j % 2 == 0) ? 3'b010 : 3'b100);
      check_eq("stream_in1", r_in1[base + j], s);
      check_eq("stream_in2", r_in2[base + j], (j / 2 == drop) ? 8'h00 : row2(s));
      check_eq("stream_in3", r_in3[base + j], (j / 2 == drop) ? 8'h00 : row3(s));
      check_eq("res_valid", r_rv[base + LAT + j], 1'b1);
      check_eq("res_hi", r_rh[base + LAT + j], (j % 2 == 1));
      check_eq("ctrl_carry", r_ctrl[base + LAT - 1 + j][3], (j % 2 == 1));
    end
    for (int j = 0; j < LAT; j++) begin
      check_eq("flush_ctrl", r_ctrl[base + 2 * N_X + j][2:0], (j % 2 == 0) ? 3'b010 : 3'b100);
      check_eq("flush_in1", r_in1[base + 2 * N_X + j], 8'h00);
    end
    for (int c = 1; c < 64; c++) begin
      if (r_ctrl[c] == 4'b0001) n_storew++;
      if (r_rv[c]) n_rv++;
      if (r_xr[c]) n_xr++;
    end
    check_eq("storew_count", n_storew, 6);
    check_eq("res_count", n_rv, 2 * N_X);
    check_eq("xready_count", n_xr, N_X);
    check_eq("underrun_end", r_und[27 + wstall], (drop >= 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
    w_data = 4'h0; x_data = 24'h0;
    #12;
    check_eq("rst_ctrl", k_ctrl, 4'b0100);
    check_eq("rst_in1", k_in1, 8'h00);
    check_eq("rst_yaux", k_yaux, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ready", {w_ready, x_ready}, 2'b00);
    check_eq("rst_res", {res_valid, res_hi, done, underrun}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(0, -1, -1);
    repeat (3) @(posedge clk);
    run_frame(3, -1, -1);
    repeat (3) @(posedge clk);
    run_frame(0, 2, -1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("underrun_sticky", underrun, 1'b1);
    run_frame(0, -1, 12);
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_after_busy_start", busy, 1'b0);

    // Reset in the middle of sample slot 2
    @(posedge clk); #1;
    start = 1'b1; w_valid = 1'b1; w_data = 4'h5;
    x_valid = 1'b1; x_data = 24'h123456;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("pre_rst_xready", x_ready, 1'b1);
    check_eq("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_ctrl", k_ctrl, 4'b0100);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_res", res_valid, 1'b0);
    w_valid = 1'b0; x_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_frame(0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
